// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolutional encoder/framer: FSM state
// encoding, stock generator sets, kept-bit popcount and parameter checking.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_TAIL  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Generator groups are written in the usual octal reading order: the
  // leftmost octal group drives coded output 0.
  localparam logic [5:0]  GEN_O75      = 6'o75;
  localparam logic [13:0] GEN_O171_133 = {7'o171, 7'o133};

  // Number of coded bits kept in one puncture step (up to four outputs).
  function automatic logic [2:0] kept_count(input logic [3:0] mask_step);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, mask_step[i]};
    end
    return n;
  endfunction

  // Legal ranges, plus every puncture step must keep at least one bit,
  // otherwise a consumed input would produce nothing to serialise.
  function automatic bit params_ok(input int n_out, input int k, input int punct_p,
                                   input logic [15:0] mask);
    bit ok;
    ok = (n_out >= 2) && (n_out <= 4) && (k >= 3) && (k <= 7) &&
         (punct_p >= 1) && (punct_p <= 4);
    if (ok) begin
      for (int p = 0; p < punct_p; p++) begin
        if (((mask >> (p * n_out)) & ((16'd1 << n_out) - 16'd1)) == 16'd0) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder memory and parity network. Holds the K-1 most recent consumed bits
// (bit K-2 newest, bit 0 oldest) and forms all N_OUT coded bits combinationally.
module conv_enc_core
  import conv_pkg::*;
#(
  parameter int                 N_OUT = 2,
  parameter int                 K     = 3,
  parameter logic [N_OUT*K-1:0] GEN   = GEN_O75
) (
  input  logic             clk_sig,
  input  logic             reset_sig,
  input  logic             shift_i,
  input  logic             bit_i,
  input  logic             clear_i,
  output logic [N_OUT-1:0] code_o
);

  logic [K-2:0] mem_q;
  logic [K-2:0] mem_d;
  logic [K-1:0] win;

  assign mem_d = {bit_i, mem_q[K-2:1]};
  assign win   = {bit_i, mem_q};

  // Output gi uses the gi-th generator group counted from the top of GEN.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_parity
    assign code_o[gi] = ^(win & GEN[(N_OUT-1-gi)*K +: K]);
  end

  // History shifts on every consumed bit and is forgotten when a frame completes.
  always_ff @(posedge clk_sig) begin
    if (!reset_sig || clear_i) begin
      mem_q <= '0;
    end else if (shift_i) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/conv_enc_framer.sv
// Rate-1/N_OUT convolutional encoder with serial output, optional zero-tail
// termination and periodic puncturing, valid/ready on both sides.
module conv_enc_framer
  import conv_pkg::*;
#(
  parameter int                         N_OUT      = 2,
  parameter int                         K          = 3,
  parameter logic [N_OUT*K-1:0]         GEN        = (K == 7) ? (N_OUT*K)'(GEN_O171_133)
                                                              : (N_OUT*K)'(GEN_O75),
  parameter bit                         TAIL_EN    = 1'b1,
  parameter int                         PUNCT_P    = 1,
  parameter logic [PUNCT_P*N_OUT-1:0]   PUNCT_MASK = '1
) (
  input  logic clk_sig,
  input  logic reset_sig,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_last,
  output logic busy
);

  localparam int PCW = $clog2(N_OUT + 1);
  localparam int TCW = $clog2(K);
  localparam int PIW = (PUNCT_P > 1) ? $clog2(PUNCT_P) : 1;

  if (!params_ok(N_OUT, K, PUNCT_P, 16'(PUNCT_MASK))) begin : g_param_check
    $error("conv_enc_framer: illegal N_OUT/K/PUNCT_P/PUNCT_MASK combination");
  end

  state_e           state_q, state_d;
  logic [PCW-1:0]   pend_q, pend_d;
  logic [TCW-1:0]   tail_q, tail_d;
  logic [PIW-1:0]   pidx_q, pidx_d;
  logic [N_OUT-1:0] sr_q, sr_d;
  logic             last_q, last_d;

  logic             slot_free, data_take, tail_take, consume;
  logic             step_bit, step_last, out_fire, frame_done;
  logic [N_OUT-1:0] code, mask_step, packed_bits;
  logic [3:0]       mask_ext;

  // A slot is free when the serialiser is empty or drains its last bit now.
  assign out_valid  = (pend_q != '0);
  assign out_fire   = out_valid && out_ready;
  assign out_bit    = out_valid && sr_q[0];
  assign out_last   = out_valid && last_q && (pend_q == PCW'(1));
  assign frame_done = out_last && out_ready;
  assign slot_free  = (pend_q == '0) || ((pend_q == PCW'(1)) && out_ready);
  assign in_ready   = reset_sig && ((state_q == ST_IDLE) || (state_q == ST_DATA)) && slot_free;
  assign data_take  = in_valid && in_ready;
  assign tail_take  = (state_q == ST_TAIL) && slot_free;
  assign consume    = data_take || tail_take;
  assign step_bit   = data_take ? in_bit : 1'b0;
  assign step_last  = data_take ? (in_last && !TAIL_EN) : (tail_q == TCW'(1));
  assign busy       = (state_q != ST_IDLE);
  assign mask_step  = PUNCT_MASK[pidx_q*N_OUT +: N_OUT];
  assign mask_ext   = 4'(mask_step);

  conv_enc_core #(
    .N_OUT (N_OUT),
    .K     (K),
    .GEN   (GEN)
  ) u_core (
    .clk_sig   (clk_sig),
    .reset_sig (reset_sig),
    .shift_i   (consume),
    .bit_i     (step_bit),
    .clear_i   (frame_done),
    .code_o    (code)
  );

  // Compact the kept outputs of this step into the low end of the serialiser word, output 0 first.
  always_comb begin
    int rank;
    packed_bits = '0;
    rank        = 0;
    for (int j = 0; j < N_OUT; j++) begin
      for (int r = 0; r < N_OUT; r++) begin
        if (mask_step[j] && (rank == r)) packed_bits[r] = code[j];
      end
      if (mask_step[j]) rank = rank + 1;
    end
  end

  // Frame sequencing, tail countdown, puncture index and serialiser next state.
  always_comb begin
    state_d = state_q;
    tail_d  = tail_q;
    pidx_d  = pidx_q;
    sr_d    = sr_q;
    pend_d  = pend_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (data_take) begin
          if (in_last) begin
            state_d = TAIL_EN ? ST_TAIL : ST_FLUSH;
            tail_d  = TCW'(K - 1);
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_TAIL: begin
        if (tail_take) begin
          tail_d = tail_q - TCW'(1);
          if (tail_q == TCW'(1)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (frame_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new step overrides the shift: it only happens when the last bit leaves now.
    if (consume) begin
      sr_d   = packed_bits;
      pend_d = PCW'(kept_count(mask_ext));
      last_d = step_last;
      pidx_d = (pidx_q == PIW'(PUNCT_P - 1)) ? '0 : pidx_q + PIW'(1);
    end else if (out_fire) begin
      sr_d   = sr_q >> 1;
      pend_d = pend_q - PCW'(1);
    end

    if (frame_done) pidx_d = '0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_sig) begin
    if (!reset_sig) begin
      state_q <= ST_IDLE;
      tail_q  <= '0;
      pidx_q  <= '0;
      sr_q    <= '0;
      pend_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tail_q  <= tail_d;
      pidx_q  <= pidx_d;
      sr_q    <= sr_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_conv_enc_framer.sv
// Bench for conv_enc_framer: three instances (default, punctured, no tail),
// directed frames from the expected coded sequences plus random frames checked
// against a step-by-step reference encoder.
module tb_conv_enc_framer;

  typedef bit bitq_t[$];

  logic clk_sig = 1'b0;
  logic reset_sig;
  logic in_valid_s  [3];
  logic in_bit_s    [3];
  logic in_last_s   [3];
  logic out_ready_s [3];
  logic in_ready_s  [3];
  logic out_valid_s [3];
  logic out_bit_s   [3];
  logic out_last_s  [3];
  logic busy_s      [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_sig = ~clk_sig;

  conv_enc_framer #(.N_OUT(2), .K(3), .GEN(6'o75), .TAIL_EN(1'b1), .PUNCT_P(1), .PUNCT_MASK(2'b11)) dut0 (
    .clk_sig(clk_sig), .reset_sig(reset_sig),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_bit(in_bit_s[0]), .in_last(in_last_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_bit(out_bit_s[0]),
    .out_last(out_last_s[0]), .busy(busy_s[0]));

  conv_enc_framer #(.N_OUT(2), .K(3), .GEN(6'o75), .TAIL_EN(1'b1), .PUNCT_P(2), .PUNCT_MASK(4'b0111)) dut1 (
    .clk_sig(clk_sig), .reset_sig(reset_sig),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_bit(in_bit_s[1]), .in_last(in_last_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_bit(out_bit_s[1]),
    .out_last(out_last_s[1]), .busy(busy_s[1]));

  conv_enc_framer #(.N_OUT(2), .K(3), .GEN(6'o75), .TAIL_EN(1'b0), .PUNCT_P(1), .PUNCT_MASK(2'b11)) dut2 (
    .clk_sig(clk_sig), .reset_sig(reset_sig),
    .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]), .in_bit(in_bit_s[2]), .in_last(in_last_s[2]),
    .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .out_bit(out_bit_s[2]),
    .out_last(out_last_s[2]), .busy(busy_s[2]));

  // Reference encoder: (7,5) code, output 0 uses 7 (111), output 1 uses 5 (101);
  // instance 1 keeps both bits on even steps and only output 0 on odd steps.
  function automatic bitq_t model(input int d, input bitq_t bits);
    bitq_t res;
    bitq_t seq;
    int hist[2];
    int g[2];
    int w[3];
    int p, mask, par;
    g[0] = 7;
    g[1] = 5;
    p    = (d == 1) ? 2 : 1;
    mask = (d == 1) ? 7 : 15;
    seq  = bits;
    if (d != 2) begin
      seq.push_back(1'b0);
      seq.push_back(1'b0);
    end
    hist[0] = 0;
    hist[1] = 0;
    for (int s = 0; s < seq.size(); s++) begin
      w[0] = int'(seq[s]);
      w[1] = hist[0];
      w[2] = hist[1];
      for (int j = 0; j < 2; j++) begin
        par = 0;
        for (int i = 0; i < 3; i++) begin
          if (((g[j] >> (2 - i)) & 1) != 0) par = par ^ w[i];
        end
        if (((mask >> ((s % p) * 2 + j)) & 1) != 0) res.push_back(bit'(par));
      end
      hist[1] = hist[0];
      hist[0] = w[0];
    end
    return res;
  endfunction

  // Drives one frame into instance d and checks the coded stream.
  // mode 0: always valid/ready, 1: ready pattern 1,0,0,1, 2: random gaps.
  // abort_at > 0 stops after that many coded bits have been handed over.
  task automatic run_frame(input int d, input bitq_t bits, input bitq_t expq, input int mode,
                           input int abort_at, input string tag, output int idle_cyc);
    int  idx, n_got, start, span, cyc;
    bit  accepted, done, aborted, prev_stall, prev_bit, prev_last, vld, rdy, want_last;
    idx = 0; n_got = 0; start = 0; span = 0; idle_cyc = 0;
    accepted = 0; done = 0; aborted = 0; prev_stall = 0; prev_bit = 0; prev_last = 0;
    for (cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk_sig);
      vld = (idx < bits.size()) && ((mode != 2) || ($urandom_range(3) != 0));
      in_valid_s[d] = vld;
      in_bit_s[d]   = vld ? bits[idx] : 1'($urandom);
      in_last_s[d]  = vld ? (idx == bits.size() - 1) : 1'($urandom);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = ($urandom_range(2) != 0);
      endcase
      out_ready_s[d] = rdy;
      #1;
      if (prev_stall) begin
        n_cmp++;
        if (out_valid_s[d] !== 1'b1 || out_bit_s[d] !== prev_bit || out_last_s[d] !== prev_last) begin
          n_bad++;
          $display("FAIL %s stall_hold cyc=%0d got valid/bit/last=%b%b%b want 1%b%b",
                   tag, cyc, out_valid_s[d], out_bit_s[d], out_last_s[d], prev_bit, prev_last);
        end
      end
      if (out_valid_s[d] === 1'b1 && !rdy) begin
        n_cmp++;
        if (in_ready_s[d] !== 1'b0) begin
          n_bad++;
          $display("FAIL %s in_ready_in_stall cyc=%0d got %b want 0", tag, cyc, in_ready_s[d]);
        end
      end
      if (idx == bits.size()) begin
        n_cmp++;
        if (in_ready_s[d] !== 1'b0) begin
          n_bad++;
          $display("FAIL %s in_ready_after_last cyc=%0d got %b want 0", tag, cyc, in_ready_s[d]);
        end
      end
      if (accepted) begin
        n_cmp++;
        if (busy_s[d] !== 1'b1) begin
          n_bad++;
          $display("FAIL %s busy cyc=%0d got %b want 1", tag, cyc, busy_s[d]);
        end
      end else if (busy_s[d] === 1'b0) begin
        idle_cyc++;
      end
      if (vld && in_ready_s[d] === 1'b1) begin
        if (!accepted) begin
          accepted = 1;
          start    = cyc;
        end
        idx++;
      end
      if (out_valid_s[d] === 1'b1 && rdy) begin
        n_cmp++;
        if (n_got >= expq.size()) begin
          n_bad++;
          $display("FAIL %s extra_bit index=%0d got %b want none", tag, n_got, out_bit_s[d]);
        end else if (out_bit_s[d] !== expq[n_got]) begin
          n_bad++;
          $display("FAIL %s out_bit index=%0d got %b want %b", tag, n_got, out_bit_s[d], expq[n_got]);
        end
        want_last = (n_got == expq.size() - 1);
        n_cmp++;
        if (out_last_s[d] !== want_last) begin
          n_bad++;
          $display("FAIL %s out_last index=%0d got %b want %b", tag, n_got, out_last_s[d], want_last);
        end
        n_got++;
        if (out_last_s[d] === 1'b1) begin
          done = 1;
          span = cyc - start;
        end
        if (abort_at > 0 && n_got == abort_at) aborted = 1;
      end
      prev_stall = (out_valid_s[d] === 1'b1) && !rdy;
      prev_bit   = out_bit_s[d];
      prev_last  = out_last_s[d];
      if (done || aborted) break;
    end
    @(posedge clk_sig);
    #1;
    in_valid_s[d]  = 1'b0;
    in_last_s[d]   = 1'b0;
    out_ready_s[d] = 1'b0;
    if (!aborted) begin
      n_cmp++;
      if (!done) begin
        n_bad++;
        $display("FAIL %s frame_end got no out_last after %0d bits want out_last", tag, n_got);
      end
      n_cmp++;
      if (n_got != expq.size()) begin
        n_bad++;
        $display("FAIL %s length got %0d want %0d", tag, n_got, expq.size());
      end
      if (mode == 0 && done) begin
        n_cmp++;
        if (span != expq.size()) begin
          n_bad++;
          $display("FAIL %s throughput got %0d cycles want %0d", tag, span, expq.size());
        end
      end
    end
    $display("frame %s dut%0d in_bits=%0d coded_bits=%0d expected=%0d", tag, d, bits.size(), n_got, expq.size());
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({in_ready_s[d], out_valid_s[d], out_bit_s[d], out_last_s[d], busy_s[d]} !== 5'b0) begin
        n_bad++;
        $display("FAIL %s dut%0d ready/valid/bit/last/busy got %b%b%b%b%b want 00000", tag, d,
                 in_ready_s[d], out_valid_s[d], out_bit_s[d], out_last_s[d], busy_s[d]);
      end
    end
  endtask

  task automatic test_reset();
    reset_sig = 1'b0;
    repeat (3) @(posedge clk_sig);
    @(negedge clk_sig);
    #1;
    check_all_zero("reset");
    reset_sig = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({in_ready_s[d], busy_s[d]} !== 2'b10) begin
        n_bad++;
        $display("FAIL reset_release dut%0d in_ready/busy got %b%b want 10", d, in_ready_s[d], busy_s[d]);
      end
    end
    $display("reset applied and released");
  endtask

  task automatic test_default_frame();
    bitq_t f = '{1, 0, 1, 1};
    bitq_t e = '{1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1};
    int idle;
    run_frame(0, f, e, 0, 0, "default", idle);
  endtask

  task automatic test_puncture();
    bitq_t f = '{1, 0, 1, 1};
    bitq_t e = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
    int idle;
    run_frame(1, f, e, 0, 0, "puncture", idle);
  endtask

  task automatic test_no_tail();
    bitq_t f = '{1, 0, 1, 1};
    bitq_t e = '{1, 1, 1, 0, 0, 0, 0, 1};
    int idle;
    run_frame(2, f, e, 0, 0, "no_tail_a", idle);
    run_frame(2, f, e, 0, 0, "no_tail_b", idle);
  endtask

  task automatic test_backpressure();
    bitq_t f = '{1, 0, 1, 1};
    bitq_t e = '{1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1};
    int idle;
    run_frame(0, f, e, 1, 0, "backpressure", idle);
  endtask

  task automatic test_back_to_back();
    bitq_t f1 = '{1, 1};
    bitq_t f2 = '{1};
    int idle;
    run_frame(0, f1, model(0, f1), 0, 0, "b2b_1", idle);
    run_frame(0, f2, model(0, f2), 0, 0, "b2b_2", idle);
    n_cmp++;
    if (idle > 1) begin
      n_bad++;
      $display("FAIL b2b_gap busy_low_cycles got %0d want <=1", idle);
    end
  endtask

  task automatic test_reset_midframe();
    bitq_t f = '{1, 0, 1, 1};
    bitq_t e = '{1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1};
    int idle;
    run_frame(0, f, e, 0, 5, "mid_reset_abort", idle);
    reset_sig = 1'b0;
    @(posedge clk_sig);
    @(negedge clk_sig);
    #1;
    check_all_zero("mid_reset");
    reset_sig = 1'b1;
    run_frame(0, f, e, 0, 0, "mid_reset_fresh", idle);
  endtask

  task automatic test_random();
    bitq_t f;
    int idle;
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 6; n++) begin
        f = {};
        for (int i = 0; i < int'($urandom_range(12, 1)); i++) f.push_back(1'($urandom));
        run_frame(d, f, model(d, f), 2, 0, "random", idle);
      end
    end
  endtask

  initial begin
    reset_sig = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid_s[d]  = 1'b0;
      in_bit_s[d]    = 1'b0;
      in_last_s[d]   = 1'b0;
      out_ready_s[d] = 1'b0;
    end
    test_reset();
    test_default_frame();
    test_puncture();
    test_no_tail();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
